multi_master_arbiter: RTL

- Parametrised N-master system-bus arbiter. It is the next generation of the 2-master arbiter in the bus fabric.
- It grants one master at a time, latches that master's slave select, and drives the encoded bus grant to the address/data muxes and slave decoder.
- It adds selectable fixed-priority or round-robin arbitration, a bounded bus tenure (hold timeout), and a mandatory one-cycle turnaround between tenures.

---
 rtl/multi_master_arbiter.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/multi_master_arbiter.sv
// multi_master_arbiter: N-master system-bus arbiter with fixed-priority or
// round-robin selection, bounded tenure (hold timeout) and a one-cycle
// turnaround between tenures. All outputs come straight from registers.
module multi_master_arbiter #(
   parameter int NUM_MASTERS = 4,
   parameter int SLAVE_SEL_W = 2,
   parameter int ROUND_ROBIN = 1,
   parameter int MAX_HOLD    = 16,
   parameter int GNT_W       = (NUM_MASTERS > 2) ? $clog2(NUM_MASTERS) : 1
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic [NUM_MASTERS-1:0]             m_request,
   input  logic [NUM_MASTERS*SLAVE_SEL_W-1:0] m_slave_sel,
   output logic [NUM_MASTERS-1:0]             m_grant,
   output logic [GNT_W-1:0]                   bus_grant,
   output logic [SLAVE_SEL_W-1:0]             slave_sel,
   output logic                               arbiter_busy,
   output logic                               timeout
);

   // Hold counter must count up to MAX_HOLD; keep at least one bit when disabled.
   localparam int HOLD_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
   localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);
   localparam logic [GNT_W-1:0]  LAST_IDX = GNT_W'(NUM_MASTERS - 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_GRANT = 2'd1;
   localparam logic [1:0] S_TURN  = 2'd2;

   logic [1:0]             state_q,   state_d;
   logic [NUM_MASTERS-1:0] grant_q,   grant_d;
   logic [GNT_W-1:0]       bus_q,     bus_d;
   logic [SLAVE_SEL_W-1:0] sel_q,     sel_d;
   logic                   busy_q,    busy_d;
   logic                   timeout_q, timeout_d;
   logic [HOLD_W-1:0]      hold_q,    hold_d;
   logic [GNT_W-1:0]       rr_q,      rr_d;

   logic [GNT_W-1:0]       win;
   logic [SLAVE_SEL_W-1:0] win_sel;

   // Scan requesters from ptr upward (round-robin) or from 0 (fixed priority);
   // the first set request wins.
   function automatic logic [GNT_W-1:0] pick_winner(
      input logic [NUM_MASTERS-1:0] req,
      input logic [GNT_W-1:0]       ptr
   );
      logic [GNT_W-1:0] best;
      logic [GNT_W-1:0] cand;
      logic             found;
      best  = '0;
      found = 1'b0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         if (ROUND_ROBIN != 0) cand = GNT_W'((int'(ptr) + i) % NUM_MASTERS);
         else                  cand = GNT_W'(i);
         if (!found && req[cand]) begin
            best  = cand;
            found = 1'b1;
         end
      end
      return best;
   endfunction

   // Next-state logic: winner selection, tenure tracking and turnaround.
   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      bus_d     = bus_q;
      sel_d     = sel_q;
      busy_d    = busy_q;
      timeout_d = 1'b0;
      hold_d    = hold_q;
      rr_d      = rr_q;
      win       = pick_winner(m_request, rr_q);
      win_sel   = '0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         if (win == GNT_W'(i)) win_sel = m_slave_sel[i*SLAVE_SEL_W +: SLAVE_SEL_W];
      end
      case (state_q)
         S_IDLE: begin
            if (|m_request) begin
               state_d      = S_GRANT;
               grant_d      = '0;
               grant_d[win] = 1'b1;
               bus_d        = win;
               sel_d        = win_sel;
               busy_d       = 1'b1;
               hold_d       = HOLD_W'(1);
               if (ROUND_ROBIN != 0) rr_d = (win == LAST_IDX) ? '0 : win + GNT_W'(1);
            end
         end
         S_GRANT: begin
            if (!m_request[bus_q]) begin
               state_d = S_TURN;
               grant_d = '0;
               bus_d   = '0;
               sel_d   = '0;
            end else if (MAX_HOLD != 0 && hold_q == HOLD_MAX) begin
               state_d   = S_TURN;
               grant_d   = '0;
               bus_d     = '0;
               sel_d     = '0;
               timeout_d = 1'b1;
            end else if (MAX_HOLD != 0) begin
               hold_d = hold_q + HOLD_W'(1);
            end
         end
         S_TURN: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            hold_d  = '0;
         end
         default: begin
            state_d = S_IDLE;
            grant_d = '0;
            bus_d   = '0;
            sel_d   = '0;
            busy_d  = 1'b0;
            hold_d  = '0;
         end
      endcase
   end

   // State and output registers, cleared immediately by reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= S_IDLE;
         grant_q   <= '0;
         bus_q     <= '0;
         sel_q     <= '0;
         busy_q    <= 1'b0;
         timeout_q <= 1'b0;
         hold_q    <= '0;
         rr_q      <= '0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         bus_q     <= bus_d;
         sel_q     <= sel_d;
         busy_q    <= busy_d;
         timeout_q <= timeout_d;
         hold_q    <= hold_d;
         rr_q      <= rr_d;
      end
   end

   assign m_grant      = grant_q;
   assign bus_grant    = bus_q;
   assign slave_sel    = sel_q;
   assign arbiter_busy = busy_q;
   assign timeout      = timeout_q;

endmodule
